// File: rtl/dst_stream_pkg.sv
// rtl/dst_stream_pkg.sv - shared state encoding and size defaults for dst_stream
package dst_stream_pkg;

    localparam int DST_DEPTH = 8;
    localparam int DST_AW    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/stream_skid2.sv
// rtl/stream_skid2.sv - two-entry 64-bit FIFO feeding the stream output
module stream_skid2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [63:0] pop_data,
    output logic        full,
    output logic        empty
);

    logic [63:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head entry only moves on pop, so it stays stable while the consumer stalls.
    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);

endmodule

// File: rtl/dst_stream.sv
// rtl/dst_stream.sv - drains len result-buffer words onto an AXI-Stream master
module dst_stream
    import dst_stream_pkg::*;
#(
    parameter int DEPTH = DST_DEPTH,
    parameter int AW    = DST_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    input  logic          outr,
    output logic          dst_v,
    output logic [AW-1:0] dst_a,
    input  logic [63:0]   dst_d,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [63:0]   m_axis_tdata,
    output logic          m_axis_tlast
);

    localparam logic [AW:0] LEN_MAX = DEPTH[AW:0];
    localparam logic [AW:0] ONE     = 1;

    state_e      state_q, state_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] rd_cnt_q, rd_cnt_d;
    logic [AW:0] beat_cnt_q, beat_cnt_d;
    logic        inflight_q;
    logic        done_q, done_d;
    logic        fifo_full, fifo_empty;
    logic [1:0]  occ;
    logic        pop, len_ok, credit_ok;

    assign len_ok = (len != '0) && (len <= LEN_MAX);
    assign pop    = m_axis_tvalid && m_axis_tready;
    assign occ    = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);

    // A slot freed by this cycle's pop is reusable, keeping one beat per cycle.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < ({2'b00, pop} + 3'd2);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        dst_v      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    state_d    = RUN;
                    len_d      = len;
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                end
            end
            RUN: begin
                if ((rd_cnt_q < len_q) && !outr && credit_ok) begin
                    dst_v    = 1'b1;
                    rd_cnt_d = rd_cnt_q + ONE;
                    if (rd_cnt_q + ONE == len_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            beat_cnt_d = beat_cnt_q + ONE;
            if (m_axis_tlast) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= dst_v;
            done_q     <= done_d;
        end
    end

    stream_skid2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (dst_d),
        .pop       (pop),
        .pop_data  (m_axis_tdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign dst_a         = rd_cnt_q[AW-1:0];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q + ONE == len_q);

endmodule
